// File: rtl/cr_huf_comp_seq_id_alloc.sv
// Sequence-ID allocator for the Huffman compressor: stages free IDs round-robin,
// keeps allocation order in a FIFO, and recycles IDs on sa_sm release.
module cr_huf_comp_seq_id_alloc #(
  parameter int SEQID_NUM   = 8,
  parameter int SEQID_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   alloc_vld,
  output logic [SEQID_WIDTH-1:0] alloc_seq_id,
  input  logic                   alloc_rdy,
  output logic                   ord_vld,
  output logic [SEQID_WIDTH-1:0] ord_seq_id,
  input  logic                   ord_pop,
  input  logic                   rel_vld,
  input  logic [SEQID_WIDTH-1:0] rel_seq_id,
  output logic [SEQID_WIDTH:0]   free_cnt,
  output logic                   err_rel,
  output logic                   err_pop
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_STAGED,
    ST_OWNED,
    ST_RETIRED
  } id_state_e;

  localparam logic [SEQID_WIDTH-1:0] ID_ONE  = SEQID_WIDTH'(1);
  localparam logic [SEQID_WIDTH:0]   CNT_ONE = (SEQID_WIDTH+1)'(1);

  id_state_e              id_state     [SEQID_NUM];
  id_state_e              id_state_nxt [SEQID_NUM];
  logic [SEQID_WIDTH-1:0] fifo_mem     [SEQID_NUM];
  logic [SEQID_WIDTH-1:0] rr_ptr;
  logic [SEQID_WIDTH-1:0] head;
  logic [SEQID_WIDTH-1:0] tail;
  logic [SEQID_WIDTH:0]   fifo_cnt;

  logic                   handshake;
  logic                   pop_ok;
  logic                   rel_ok;
  logic                   found;
  logic                   load;
  logic [SEQID_WIDTH-1:0] sel;
  logic [SEQID_WIDTH-1:0] idx;

  assign handshake  = alloc_vld & alloc_rdy;
  assign ord_vld    = (fifo_cnt != '0);
  assign ord_seq_id = fifo_mem[head];
  assign pop_ok     = ord_pop & ord_vld;
  assign rel_ok     = rel_vld & (id_state[rel_seq_id] == ST_RETIRED);
  assign load       = (~alloc_vld | handshake) & found;

  // First FREE ID at or above rr_ptr, wrapping; searches registered state only,
  // so a release this cycle cannot be staged before the next edge.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < SEQID_NUM; i++) begin
      idx = rr_ptr + SEQID_WIDTH'(i);
      if (!found && id_state[idx] == ST_FREE) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Load, handshake, pop and release always touch distinct IDs.
  always_comb begin
    id_state_nxt = id_state;
    if (load)      id_state_nxt[sel]          = ST_STAGED;
    if (handshake) id_state_nxt[alloc_seq_id] = ST_OWNED;
    if (pop_ok)    id_state_nxt[ord_seq_id]   = ST_RETIRED;
    if (rel_ok)    id_state_nxt[rel_seq_id]   = ST_FREE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQID_NUM; i++) id_state[i] <= ST_FREE;
      rr_ptr       <= '0;
      alloc_vld    <= 1'b0;
      alloc_seq_id <= '0;
      free_cnt     <= (SEQID_WIDTH+1)'(SEQID_NUM);
      err_rel      <= 1'b0;
      err_pop      <= 1'b0;
    end else begin
      id_state <= id_state_nxt;
      if (load) begin
        alloc_vld    <= 1'b1;
        alloc_seq_id <= sel;
        rr_ptr       <= sel + ID_ONE;
      end else if (handshake) begin
        alloc_vld <= 1'b0;
      end
      case ({rel_ok, load})
        2'b10:   free_cnt <= free_cnt + CNT_ONE;
        2'b01:   free_cnt <= free_cnt - CNT_ONE;
        default: free_cnt <= free_cnt;
      endcase
      if (rel_vld && !rel_ok)  err_rel <= 1'b1;
      if (ord_pop && !ord_vld) err_pop <= 1'b1;
    end
  end

  // Order FIFO; depth equals the ID count, so it can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the FIFO storage is reset too, so ord_seq_id reads 0 after reset rather than X.
      for (int i = 0; i < SEQID_NUM; i++) fifo_mem[i] <= '0;
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (handshake) begin
        fifo_mem[tail] <= alloc_seq_id;
        tail           <= tail + ID_ONE;
      end
      if (pop_ok) head <= head + ID_ONE;
      case ({handshake, pop_ok})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_seq_id_alloc.sv
// Directed self-checking bench for cr_huf_comp_seq_id_alloc (8 IDs); outputs sampled on negedge.
module tb_cr_huf_comp_seq_id_alloc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_vld;
  logic [2:0] alloc_seq_id;
  logic       alloc_rdy = 1'b0;
  logic       ord_vld;
  logic [2:0] ord_seq_id;
  logic       ord_pop = 1'b0;
  logic       rel_vld = 1'b0;
  logic [2:0] rel_seq_id = 3'd0;
  logic [3:0] free_cnt;
  logic       err_rel;
  logic       err_pop;

  int checks = 0;
  int failures = 0;

  cr_huf_comp_seq_id_alloc #(.SEQID_NUM(8), .SEQID_WIDTH(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_vld    (alloc_vld),
    .alloc_seq_id (alloc_seq_id),
    .alloc_rdy    (alloc_rdy),
    .ord_vld      (ord_vld),
    .ord_seq_id   (ord_seq_id),
    .ord_pop      (ord_pop),
    .rel_vld      (rel_vld),
    .rel_seq_id   (rel_seq_id),
    .free_cnt     (free_cnt),
    .err_rel      (err_rel),
    .err_pop      (err_pop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; alloc_rdy = 1'b0; ord_pop = 1'b0; rel_vld = 1'b0; rel_seq_id = 3'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (alloc_vld !== 1'b0) begin failures++; $display("FAIL reset_alloc_vld got=%b exp=0", alloc_vld); end
    checks++; if (alloc_seq_id !== 3'd0) begin failures++; $display("FAIL reset_alloc_seq_id got=%0d exp=0", alloc_seq_id); end
    checks++; if (ord_vld !== 1'b0 || ord_seq_id !== 3'd0) begin failures++; $display("FAIL reset_ord got=%b/%0d exp=0/0", ord_vld, ord_seq_id); end
    checks++; if (free_cnt !== 4'd8) begin failures++; $display("FAIL reset_free_cnt got=%0d exp=8", free_cnt); end
    checks++; if (err_rel !== 1'b0 || err_pop !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", err_rel, err_pop); end
    rst_n = 1'b1;
    tick();
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd0) begin failures++; $display("FAIL first_alloc got=%b/%0d exp=1/0", alloc_vld, alloc_seq_id); end
    checks++; if (free_cnt !== 4'd7) begin failures++; $display("FAIL first_free_cnt got=%0d exp=7", free_cnt); end
  endtask

  task automatic test_sequential_alloc();
    do_reset();
    alloc_rdy = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'(k)) begin failures++; $display("FAIL seq_alloc_%0d got=%b/%0d exp=1/%0d", k, alloc_vld, alloc_seq_id, k); end
    end
    checks++; if (free_cnt !== 4'd0) begin failures++; $display("FAIL seq_free_cnt_zero got=%0d exp=0", free_cnt); end
    tick();
    alloc_rdy = 1'b0;
    checks++; if (alloc_vld !== 1'b0) begin failures++; $display("FAIL seq_exhausted_vld got=%b exp=0", alloc_vld); end
    checks++; if (ord_vld !== 1'b1 || ord_seq_id !== 3'd0) begin failures++; $display("FAIL seq_ord_head got=%b/%0d exp=1/0", ord_vld, ord_seq_id); end
    tick();
    checks++; if (alloc_vld !== 1'b0 || free_cnt !== 4'd0) begin failures++; $display("FAIL seq_stay_empty got=%b/%0d exp=0/0", alloc_vld, free_cnt); end
  endtask

  // Continues from the exhausted state left by test_sequential_alloc.
  task automatic test_release_reuse();
    ord_pop = 1'b1;
    tick();
    checks++; if (ord_seq_id !== 3'd1) begin failures++; $display("FAIL rel_pop0_head got=%0d exp=1", ord_seq_id); end
    tick();
    ord_pop = 1'b0;
    checks++; if (ord_seq_id !== 3'd2) begin failures++; $display("FAIL rel_pop1_head got=%0d exp=2", ord_seq_id); end
    rel_vld = 1'b1; rel_seq_id = 3'd1;
    tick();
    rel_vld = 1'b0;
    checks++; if (free_cnt !== 4'd1 || alloc_vld !== 1'b0) begin failures++; $display("FAIL rel_free_next got=%0d/%b exp=1/0", free_cnt, alloc_vld); end
    tick();
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd1) begin failures++; $display("FAIL rel_reuse got=%b/%0d exp=1/1", alloc_vld, alloc_seq_id); end
    checks++; if (free_cnt !== 4'd0) begin failures++; $display("FAIL rel_reuse_cnt got=%0d exp=0", free_cnt); end
    rel_vld = 1'b1; rel_seq_id = 3'd0;
    tick();
    rel_vld = 1'b0;
    checks++; if (err_rel !== 1'b0 || free_cnt !== 4'd1) begin failures++; $display("FAIL rel_id0_retired got=%b/%0d exp=0/1", err_rel, free_cnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ids [5];
    exp_ids = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    do_reset();
    alloc_rdy = 1'b1;
    repeat (3) tick();
    alloc_rdy = 1'b0;
    ord_pop = 1'b1;
    repeat (2) tick();
    ord_pop = 1'b0;
    rel_vld = 1'b1; rel_seq_id = 3'd1;
    tick();
    rel_vld = 1'b0;
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd3) begin failures++; $display("FAIL rr_hold3 got=%b/%0d exp=1/3", alloc_vld, alloc_seq_id); end
    alloc_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== exp_ids[k]) begin failures++; $display("FAIL rr_step%0d got=%b/%0d exp=1/%0d", k, alloc_vld, alloc_seq_id, exp_ids[k]); end
    end
    tick();
    alloc_rdy = 1'b0;
    checks++; if (alloc_vld !== 1'b0 || free_cnt !== 4'd0) begin failures++; $display("FAIL rr_exhausted got=%b/%0d exp=0/0", alloc_vld, free_cnt); end
  endtask

  // Continues from test_round_robin: FIFO holds 2,3,4,5,6,7,1.
  task automatic test_illegal_release();
    rel_vld = 1'b1; rel_seq_id = 3'd5;
    tick();
    rel_vld = 1'b0;
    checks++; if (err_rel !== 1'b1) begin failures++; $display("FAIL illegal_rel_flag got=%b exp=1", err_rel); end
    checks++; if (free_cnt !== 4'd0 || err_pop !== 1'b0) begin failures++; $display("FAIL illegal_rel_side got=%0d/%b exp=0/0", free_cnt, err_pop); end
    ord_pop = 1'b1;
    repeat (3) tick();
    ord_pop = 1'b0;
    checks++; if (ord_vld !== 1'b1 || ord_seq_id !== 3'd5) begin failures++; $display("FAIL illegal_rel_kept got=%b/%0d exp=1/5", ord_vld, ord_seq_id); end
  endtask

  task automatic test_err_pop();
    do_reset();
    ord_pop = 1'b1;
    tick();
    ord_pop = 1'b0;
    checks++; if (err_pop !== 1'b1 || err_rel !== 1'b0) begin failures++; $display("FAIL err_pop_flag got=%b/%b exp=1/0", err_pop, err_rel); end
    checks++; if (ord_vld !== 1'b0) begin failures++; $display("FAIL err_pop_ord_vld got=%b exp=0", ord_vld); end
    tick();
    checks++; if (err_pop !== 1'b1) begin failures++; $display("FAIL err_pop_sticky got=%b exp=1", err_pop); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_rdy = 1'b1;
    repeat (4) tick();
    alloc_rdy = 1'b0;
    checks++; if (alloc_seq_id !== 3'd4) begin failures++; $display("FAIL b2b_stage4 got=%0d exp=4", alloc_seq_id); end
    ord_pop = 1'b1;
    tick();
    alloc_rdy = 1'b1; rel_vld = 1'b1; rel_seq_id = 3'd0;
    tick();
    alloc_rdy = 1'b0; ord_pop = 1'b0; rel_vld = 1'b0;
    checks++; if (ord_seq_id !== 3'd2) begin failures++; $display("FAIL b2b_head got=%0d exp=2", ord_seq_id); end
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd5) begin failures++; $display("FAIL b2b_next_stage got=%b/%0d exp=1/5", alloc_vld, alloc_seq_id); end
    checks++; if (free_cnt !== 4'd3) begin failures++; $display("FAIL b2b_free_cnt got=%0d exp=3", free_cnt); end
    checks++; if (err_rel !== 1'b0 || err_pop !== 1'b0) begin failures++; $display("FAIL b2b_errs got=%b%b exp=00", err_rel, err_pop); end
    ord_pop = 1'b1;
    repeat (2) tick();
    checks++; if (ord_seq_id !== 3'd4) begin failures++; $display("FAIL b2b_tail4 got=%0d exp=4", ord_seq_id); end
    tick();
    ord_pop = 1'b0;
    checks++; if (ord_vld !== 1'b0 || err_pop !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b/%b exp=0/0", ord_vld, err_pop); end
    alloc_rdy = 1'b1;
    tick();
    checks++; if (alloc_seq_id !== 3'd6) begin failures++; $display("FAIL b2b_wrap6 got=%0d exp=6", alloc_seq_id); end
    tick();
    checks++; if (alloc_seq_id !== 3'd7) begin failures++; $display("FAIL b2b_wrap7 got=%0d exp=7", alloc_seq_id); end
    tick();
    alloc_rdy = 1'b0;
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd0) begin failures++; $display("FAIL b2b_reuse0 got=%b/%0d exp=1/0", alloc_vld, alloc_seq_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_rdy = 1'b1;
    repeat (5) tick();
    alloc_rdy = 1'b0;
    checks++; if (alloc_seq_id !== 3'd5 || free_cnt !== 4'd2) begin failures++; $display("FAIL mid_pre got=%0d/%0d exp=5/2", alloc_seq_id, free_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (alloc_vld !== 1'b0 || alloc_seq_id !== 3'd0) begin failures++; $display("FAIL mid_async_alloc got=%b/%0d exp=0/0", alloc_vld, alloc_seq_id); end
    checks++; if (ord_vld !== 1'b0 || ord_seq_id !== 3'd0) begin failures++; $display("FAIL mid_async_ord got=%b/%0d exp=0/0", ord_vld, ord_seq_id); end
    checks++; if (free_cnt !== 4'd8) begin failures++; $display("FAIL mid_async_free got=%0d exp=8", free_cnt); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (alloc_vld !== 1'b0 || free_cnt !== 4'd8) begin failures++; $display("FAIL mid_released got=%b/%0d exp=0/8", alloc_vld, free_cnt); end
    tick();
    checks++; if (alloc_vld !== 1'b1 || alloc_seq_id !== 3'd0 || free_cnt !== 4'd7) begin failures++; $display("FAIL mid_first got=%b/%0d/%0d exp=1/0/7", alloc_vld, alloc_seq_id, free_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential_alloc();
    test_release_reuse();
    test_round_robin();
    test_illegal_release();
    test_err_pop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
